serial_deserializer: RTL and testbench
======================================

Name: serial_deserializer

Overview:
- Receive end of the team's shift-register serial link: collects a qualified serial bit stream into N-bit parallel words.
- Supports MSB-first (left-shift fill) and LSB-first (right-shift fill) framing, selected per word.
- Presents completed words on a valid/ready parallel output with one word of buffering.
- Flags words lost to back-pressure with a sticky overflow flag.
- Sits between a serial shifter/transmitter and a parallel consumer.

Parameters:
- N, 8, word width in bits; legal N >= 2. Bit counter width is $clog2(N).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- sin  input  1  serial data bit.
- sin_valid  input  1  sin carries a bit this cycle.
- msb_first  input  1  1 = first bit of word is MSB; 0 = first bit is LSB.
- flush  input  1  synchronous abort of the partial word.
- out_data  output  N  completed word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- overflow  output  1  sticky: a completed word was dropped.
- ovf_clr  input  1  clears overflow.
- bit_cnt  output  $clog2(N)  bits collected in the current partial word.

Behaviour:
- Reset (reset==0 at a clk edge) clears the shift register, bit_cnt, out_data, out_valid, overflow and the latched direction. It has priority over all other inputs, including mid-word and while holding a word.
- Direction latch: msb_first is sampled only on the beat where bit_cnt==0 && sin_valid and is held for the rest of that word. Changes to msb_first mid-word are ignored.
- Shift on each beat (sin_valid==1):
  - MSB-first: sr <= {sr[N-2:0], sin}.
  - LSB-first: sr <= {sin, sr[N-1:1]}.
  - bit_cnt increments on each beat.
- No beat (sin_valid==0): shift register and bit_cnt hold.
- Word completion is the beat with bit_cnt==N-1.
  - The assembled word, including the current bit, becomes the completed word.
  - bit_cnt wraps to 0 on the same edge.
  - out_data/out_valid update on that same edge, so out_valid is high the cycle after the Nth beat (latency 1).
- Back-to-back words: a completion beat directly followed by further sin_valid beats must be accepted with no gap cycles.
- Output register:
  - out_valid && out_ready with no completion: out_valid clears next edge; out_data holds its last value.
  - Completion while out_valid==0: load the word, set out_valid.
  - Completion while out_valid && out_ready in the same cycle: load the new word, out_valid stays 1.
  - Completion while out_valid && !out_ready: new word is dropped, out_data unchanged, overflow <= 1.
- overflow: sticky until ovf_clr. If ovf_clr and a new drop occur in the same cycle, set wins (overflow stays 1).
- flush:
  - Clears bit_cnt and the shift register; the partial word is discarded.
  - Does not affect out_data, out_valid or overflow.
  - flush with sin_valid in the same cycle: flush wins and the bit is discarded; the next beat starts a new word.
- State machine: two states.
  - EMPTY (out_valid=0) -> FULL on completion.
  - FULL -> EMPTY on handshake without completion.
  - FULL -> FULL on completion with handshake (reload) or completion without handshake (drop).
- Collection continues independently of output state; input is never back-pressured.

Test Plan:
- Reset then MSB-first, N=8, beats sin=1,1,0,0,0,0,0,1 with out_ready=1 -> out_valid pulses 1 cycle after the 8th beat, out_data=0xC1, overflow=0.
- Same bits with msb_first=0 -> out_data=0x83. Toggling msb_first after beat 3 leaves the result 0x83.
- sin_valid gaps (beats every 3rd cycle) -> same 0xC1. bit_cnt holds between beats and reads 0..7 then wraps to 0.
- out_ready=0, send 0xC1 then 16 more beats forming 0x5A and 0x3C:
  - out_data stays 0xC1 and overflow=1 after the 2nd word.
  - ovf_clr pulse -> overflow=0.
  - ovf_clr coincident with the 3rd word's drop -> overflow stays 1.
- Completion beat for 0x5A in the same cycle as the out_ready handshake of 0xC1 -> next cycle out_data=0x5A, out_valid=1, no overflow.
- Mid-operation abort, each on a separate run:
  - flush after 5 beats, then 8 beats of 0xA5 -> out_data=0xA5.
  - reset=0 after 5 beats, or while out_valid=1 -> all outputs 0 next cycle, subsequent word assembles correctly.

Source files
------------

// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//
// This is the receive end of the serial link. It collects a qualified serial
// bit stream into N-bit parallel words. The framing is chosen per word:
// MSB-first uses left-shift fill and LSB-first uses right-shift fill.
//
// Completed words go out on a valid/ready interface that holds one word.
// If a word completes while the held word is still waiting, the new word is
// dropped and a sticky overflow flag is set.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   sin        serial data bit
//   sin_valid  sin carries a bit this cycle
//   msb_first  1 = first bit of the word is the MSB; sampled on the first beat only
//   flush      discard the partial word
//   out_data   completed word
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer accepts out_data when out_valid && out_ready
//   overflow   sticky: a completed word was dropped
//   ovf_clr    clears overflow (a drop in the same cycle wins)
//   bit_cnt    bits collected in the current partial word
// -----------------------------------------------------------------------------
module serial_deserializer #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sin,
    input  logic                 sin_valid,
    input  logic                 msb_first,
    input  logic                 flush,
    output logic [N-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overflow,
    input  logic                 ovf_clr,
    output logic [$clog2(N)-1:0] bit_cnt
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    sr_q, sr_d;
    logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [N-1:0]    out_data_q, out_data_d;
    logic            overflow_q, overflow_d;
    logic            dir_q, dir_d;

    logic            beat;
    logic            complete;
    logic            handshake;
    logic            dir_now;
    logic [N-1:0]    msb_vec;
    logic [N-1:0]    lsb_vec;
    logic [N-1:0]    shifted;

    // A flush in the same cycle as a beat discards that bit.
    assign beat      = sin_valid && !flush;
    assign complete  = beat && (bit_cnt_q == LAST_BIT);
    assign handshake = out_valid && out_ready;

    // On the first beat of a word the live msb_first applies. After that,
    // the direction latched on that first beat is used.
    assign dir_now = (bit_cnt_q == '0) ? msb_first : dir_q;

    // Build both shifted candidates bit by bit.
    // The MSB-first candidate enters the new bit at bit 0.
    // The LSB-first candidate enters the new bit at bit N-1.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_shift
            if (gi == 0) begin : g_msb_in
                assign msb_vec[gi] = sin;
            end else begin : g_msb_sh
                assign msb_vec[gi] = sr_q[gi-1];
            end
            if (gi == N - 1) begin : g_lsb_in
                assign lsb_vec[gi] = sin;
            end else begin : g_lsb_sh
                assign lsb_vec[gi] = sr_q[gi+1];
            end
        end
    endgenerate

    assign shifted = dir_now ? msb_vec : lsb_vec;

    // ---------------- Collection datapath ----------------
    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        dir_d     = dir_q;
        if (flush) begin
            sr_d      = '0;
            bit_cnt_d = '0;
        end else if (beat) begin
            if (bit_cnt_q == '0) begin
                dir_d = msb_first;
            end
            if (complete) begin
                // The next word overwrites every bit, so start it from a clean register.
                sr_d      = '0;
                bit_cnt_d = '0;
            end else begin
                sr_d      = shifted;
                bit_cnt_d = bit_cnt_q + CW'(1);
            end
        end
    end

    // ---------------- Output register and overflow ----------------
    always_comb begin
        out_data_d = out_data_q;
        overflow_d = overflow_q;
        if (complete && (!out_valid || out_ready)) begin
            out_data_d = shifted;
        end
        if (complete && out_valid && !out_ready) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            dir_q      <= 1'b0;
            out_data_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            dir_q      <= dir_d;
            out_data_q <= out_data_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------- Output buffer FSM ----------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (complete) state_d = FULL;
            FULL:  if (!complete && handshake) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
    end

    assign out_data = out_data_q;
    assign overflow = overflow_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
//
// Directed testbench for serial_deserializer with N=8.
// Inputs are driven 1 ns after each rising edge. Outputs are checked at the
// same point, after the edge they respond to.
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       reset;
    logic       sin;
    logic       sin_valid;
    logic       msb_first;
    logic       flush;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;
    logic       ovf_clr;
    logic [2:0] bit_cnt;

    int pass_cnt = 0;
    int check_cnt = 0;

    serial_deserializer #(.N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sin_valid (sin_valid),
        .msb_first (msb_first),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %-22s got=0x%0h exp=0x%0h ok", tag, got, exp);
        end else begin
            $display("FAIL %-22s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one qualified bit for one cycle.
    task automatic beat(input logic b, input logic msb);
        sin       = b;
        msb_first = msb;
        sin_valid = 1'b1;
        tick();
        sin_valid = 1'b0;
    endtask

    // Send the 8 bits of w in the order the selected framing implies,
    // with `gap` idle cycles after each beat.
    task automatic send_word(input logic [7:0] w, input logic msb, input int gap);
        for (int i = 0; i < 8; i++) begin
            beat(msb ? w[7-i] : w[i], msb);
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        sin       = 1'b0;
        sin_valid = 1'b0;
        msb_first = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;

        // Reset state
        tick();
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_data",     32'(out_data),  32'h00);
        chk("rst_overflow", 32'(overflow),  32'd0);
        chk("rst_bitcnt",   32'(bit_cnt),   32'd0);
        reset = 1'b1;

        // MSB-first: bits 1,1,0,0,0,0,0,1 -> 0xC1
        send_word(8'hC1, 1'b1, 0);
        chk("msb_valid",    32'(out_valid), 32'd1);
        chk("msb_data",     32'(out_data),  32'hC1);
        chk("msb_overflow", 32'(overflow),  32'd0);
        chk("msb_bitcnt",   32'(bit_cnt),   32'd0);
        tick();
        chk("msb_valid_pulse", 32'(out_valid), 32'd0);
        chk("msb_data_hold",   32'(out_data),  32'hC1);

        // The same bit order with LSB-first framing gives 0x83
        send_word(8'h83, 1'b0, 0);
        chk("lsb_valid", 32'(out_valid), 32'd1);
        chk("lsb_data",  32'(out_data),  32'h83);
        tick();

        // Toggling msb_first after beat 3 is ignored
        begin
            logic [7:0] w;
            w = 8'h83;
            for (int i = 0; i < 8; i++) beat(w[i], (i >= 3));
        end
        chk("lsb_toggle_data", 32'(out_data), 32'h83);
        tick();

        // Beats every third cycle; bit_cnt must hold between beats
        begin
            logic [7:0] w;
            w = 8'hC1;
            for (int i = 0; i < 8; i++) begin
                beat(w[7-i], 1'b1);
                chk($sformatf("gap_bitcnt_b%0d", i), 32'(bit_cnt), 32'((i + 1) % 8));
                tick();
                tick();
                chk($sformatf("gap_bitcnt_h%0d", i), 32'(bit_cnt),
                    (i == 7) ? 32'd0 : 32'(i + 1));
            end
        end
        chk("gap_data", 32'(out_data), 32'hC1);

        // Back-pressure: hold 0xC1, then drop 0x5A and 0x3C
        out_ready = 1'b0;
        send_word(8'hC1, 1'b1, 0);
        chk("bp_valid1", 32'(out_valid), 32'd1);
        chk("bp_data1",  32'(out_data),  32'hC1);
        chk("bp_ovf1",   32'(overflow),  32'd0);
        send_word(8'h5A, 1'b1, 0);
        chk("bp_data2",  32'(out_data),  32'hC1);
        chk("bp_ovf2",   32'(overflow),  32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("bp_ovf_clr", 32'(overflow), 32'd0);
        begin
            logic [7:0] w;
            w = 8'h3C;
            for (int i = 0; i < 7; i++) beat(w[7-i], 1'b1);
            ovf_clr = 1'b1;
            beat(w[0], 1'b1);
            ovf_clr = 1'b0;
        end
        chk("bp_ovf_set_wins", 32'(overflow),  32'd1);
        chk("bp_data3",        32'(out_data),  32'hC1);
        chk("bp_valid3",       32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_drain_valid", 32'(out_valid), 32'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("bp_ovf_clr2", 32'(overflow), 32'd0);

        // A completion in the same cycle as the handshake reloads the buffer
        out_ready = 1'b0;
        send_word(8'hC1, 1'b1, 0);
        begin
            logic [7:0] w;
            w = 8'h5A;
            for (int i = 0; i < 7; i++) beat(w[7-i], 1'b1);
            out_ready = 1'b1;
            beat(w[0], 1'b1);
        end
        chk("reload_data",  32'(out_data),  32'h5A);
        chk("reload_valid", 32'(out_valid), 32'd1);
        chk("reload_ovf",   32'(overflow),  32'd0);
        tick();
        chk("reload_drain", 32'(out_valid), 32'd0);

        // Flush after 5 beats; a beat in the flush cycle is discarded
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b1);
        chk("flush_pre_bitcnt", 32'(bit_cnt), 32'd5);
        flush     = 1'b1;
        sin       = 1'b1;
        sin_valid = 1'b1;
        tick();
        flush     = 1'b0;
        sin_valid = 1'b0;
        chk("flush_bitcnt", 32'(bit_cnt),   32'd0);
        chk("flush_valid",  32'(out_valid), 32'd0);
        chk("flush_data",   32'(out_data),  32'h5A);
        send_word(8'hA5, 1'b1, 0);
        chk("flush_word", 32'(out_data), 32'hA5);
        chk("flush_word_valid", 32'(out_valid), 32'd1);
        tick();

        // Reset after 5 beats
        for (int i = 0; i < 5; i++) beat(1'b1, 1'b1);
        do_reset();
        chk("mid_rst_bitcnt", 32'(bit_cnt),   32'd0);
        chk("mid_rst_data",   32'(out_data),  32'h00);
        chk("mid_rst_valid",  32'(out_valid), 32'd0);
        chk("mid_rst_ovf",    32'(overflow),  32'd0);
        send_word(8'h5A, 1'b1, 0);
        chk("mid_rst_word", 32'(out_data), 32'h5A);
        tick();

        // Reset while holding a word and with overflow set
        out_ready = 1'b0;
        send_word(8'hC1, 1'b1, 0);
        send_word(8'hFF, 1'b1, 0);
        chk("hold_rst_pre_ovf", 32'(overflow), 32'd1);
        do_reset();
        chk("hold_rst_valid", 32'(out_valid), 32'd0);
        chk("hold_rst_data",  32'(out_data),  32'h00);
        chk("hold_rst_ovf",   32'(overflow),  32'd0);
        out_ready = 1'b1;
        send_word(8'h3C, 1'b0, 0);
        chk("hold_rst_word",  32'(out_data),  32'h3C);
        chk("hold_rst_wvld",  32'(out_valid), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
